// File: rtl/shift_rotate_seq.sv
// Sequential SHR/SHRA/SHL/ROR/ROL unit with a start/busy/done handshake; one bit position per clock.
// Define SHIFT_FAST_EN to replace the bit-serial loop with a single-cycle barrel shift.
module shift_rotate_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [31:0]      shift_amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx, step;
  logic [2:0]       op_r, op_nx;
  logic [5:0]       count, count_nx, eff;
  logic             ill_r, ill_nx;
  logic             accept, op_ok;
  logic             busy_nx, done_nx, zero_nx, illegal_nx;
  logic [WIDTH-1:0] result_nx;

  assign accept = (state == IDLE) && start;
  assign op_ok  = (op <= OP_ROL);

  // Rotates wrap modulo 32; plain shifts saturate at 32 (everything shifted out).
  always_comb begin
    eff = 6'd0;
    if (op_ok) begin
      if (op == OP_ROR || op == OP_ROL)
        eff = {1'b0, shift_amount[4:0]};
      else if (shift_amount >= 32'd32)
        eff = 6'd32;
      else
        eff = shift_amount[5:0];
    end
  end

`ifdef SHIFT_FAST_EN
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] d,
                                               input logic [2:0]       o,
                                               input logic [5:0]       n);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SHR:  r = d >> n;
      OP_SHRA: r = $signed(d) >>> n;
      OP_SHL:  r = d << n;
      OP_ROR:  r = (d >> n) | (d << (6'd32 - n));
      OP_ROL:  r = (d << n) | (d >> (6'd32 - n));
      default: r = d;
    endcase
    return r;
  endfunction
`endif

  always_comb begin
    case (op_r)
      OP_SHR:  step = {1'b0, acc[WIDTH-1:1]};
      OP_SHRA: step = {acc[WIDTH-1], acc[WIDTH-1:1]};
      OP_SHL:  step = {acc[WIDTH-2:0], 1'b0};
      OP_ROR:  step = {acc[0], acc[WIDTH-1:1]};
      OP_ROL:  step = {acc[WIDTH-2:0], acc[WIDTH-1]};
      default: step = acc;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      acc     <= '0;
      op_r    <= 3'd0;
      count   <= 6'd0;
      ill_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      op_r    <= op_nx;
      count   <= count_nx;
      ill_r   <= ill_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      result  <= result_nx;
      zero    <= zero_nx;
      illegal <= illegal_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef SHIFT_FAST_EN
          state_nx = DONE;
`else
          state_nx = (eff == 6'd0) ? DONE : SHIFT;
`endif
        end
      end
      SHIFT:   if (count == 6'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The result stage captures acc while the FSM sits in DONE, so done/result appear one cycle later.
  always_comb begin
    acc_nx     = acc;
    op_nx      = op_r;
    count_nx   = count;
    ill_nx     = ill_r;
    result_nx  = result;
    zero_nx    = zero;
    illegal_nx = illegal;
    if (accept) begin
`ifdef SHIFT_FAST_EN
      acc_nx = barrel(data_in, op, eff);
`else
      acc_nx = data_in;
`endif
      op_nx      = op;
      count_nx   = eff;
      ill_nx     = !op_ok;
      illegal_nx = 1'b0;
    end else if (state == SHIFT) begin
      acc_nx   = step;
      count_nx = count - 6'd1;
    end
    if (state == DONE) begin
      result_nx  = acc;
      zero_nx    = (acc == '0);
      illegal_nx = ill_r;
    end
    done_nx = (state == DONE);
    busy_nx = (state_nx != IDLE) || (state == DONE);
  end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Scoreboard bench for shift_rotate_seq: directed and random operations against an arithmetic model.
// Latency expectations follow SHIFT_FAST_EN when it is defined for the build.
module tb_shift_rotate_seq;

`ifdef SHIFT_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [31:0] shift_amount;
  logic        busy, done, zero, illegal;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          acc_edge;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  shift_rotate_seq #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .data_in(data_in),
    .shift_amount(shift_amount), .busy(busy), .done(done), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: shifts as plain arithmetic, rotates as a window into a doubled operand.
  task automatic model(input logic [2:0] o, input logic [31:0] d, input logic [31:0] amt,
                       output logic [31:0] r, output logic ill, output int eff);
    logic [63:0] dd;
    int          sat, rot, n;
    sat = (amt >= 32) ? 32 : int'(amt);
    rot = int'(amt[4:0]);
    dd  = {d, d};
    ill = 1'b0;
    case (o)
      3'd0: begin eff = sat; r = (sat >= 32) ? 32'd0 : d >> sat; end
      3'd1: begin eff = sat; r = (sat >= 32) ? {32{d[31]}} : 32'($signed(d) >>> sat); end
      3'd2: begin eff = sat; r = (sat >= 32) ? 32'd0 : d << sat; end
      3'd3: begin eff = rot; r = dd[rot +: 32]; end
      3'd4: begin eff = rot; n = (32 - rot) % 32; r = dd[n +: 32]; end
      default: begin eff = 0; r = d; ill = 1'b1; end
    endcase
  endtask

  task automatic make_exp(input logic [2:0] o, input logic [31:0] d, input logic [31:0] amt,
                          input int edge_no, output exp_t e, output int eff);
    model(o, d, amt, e.res, e.ill, eff);
    e.z        = (e.res == 32'd0);
    e.acc_edge = edge_no;
    e.lat      = FAST ? 1 : eff + 1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 60);
    chk({nm, "_timeout"}, done, 1'b1);
  endtask

  task automatic scramble();
    op           = 3'($urandom);
    data_in      = $urandom;
    shift_amount = $urandom;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic [31:0] amt,
                       input bit poke, input bit wait_it);
    exp_t e;
    int   eff;
    make_exp(o, d, amt, cyc + 1, e, eff);
    op = o; data_in = d; shift_amount = amt; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    scramble();
    // A second request while shifting must not be queued or restart the unit.
    if (poke && !FAST && eff >= 3) begin
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    if (wait_it) wait_done("op");
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!clear && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", done, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("result",  result, e.res);
        chk("zero",    zero, e.z);
        chk("illegal", illegal, e.ill);
        chk("latency", cyc - e.acc_edge, e.lat);
        chk("busy_at_done", busy, 1'b1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation stuck at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1, e2;
    int   eff1, eff2;
    logic [2:0]  ro;
    logic [31:0] rd, ra;

    clear = 1'b1; start = 1'b0; op = 3'd0; data_in = '0; shift_amount = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_illegal", illegal, 1'b0);
    clear = 1'b0;

    issue(3'd1, 32'hFFFF_FFFA, 32'd1,  0, 1);
    issue(3'd0, 32'd5,         32'd3,  0, 1);
    issue(3'd2, 32'd6,         32'd1,  0, 1);
    issue(3'd4, 32'h8000_0001, 32'd1,  0, 1);
    issue(3'd3, 32'h8000_0001, 32'd33, 0, 1);
    issue(3'd1, 32'h8000_0000, 32'd40, 1, 1);
    issue(3'd0, 32'h8000_0000, 32'd40, 0, 1);
    issue(3'd2, 32'hFFFF_FFFF, 32'd32, 0, 1);
    issue(3'd7, 32'h0000_1234, 32'd7,  0, 1);
    chk("illegal_held", illegal, 1'b1);
    issue(3'd0, 32'h0000_0055, 32'd0,  0, 1);
    chk("illegal_cleared", illegal, 1'b0);

    // Held start: the second operation is accepted in the idle cycle right after done.
    make_exp(3'd2, 32'h0000_0F0F, 32'd4, cyc + 1, e1, eff1);
    op = 3'd2; data_in = 32'h0000_0F0F; shift_amount = 32'd4; start = 1'b1;
    exp_q.push_back(e1);
    @(negedge clock);
    make_exp(3'd3, 32'h0000_00FF, 32'd4, e1.acc_edge + e1.lat + 1, e2, eff2);
    op = 3'd3; data_in = 32'h0000_00FF; shift_amount = 32'd4;
    exp_q.push_back(e2);
    wait_done("held_a");
    @(negedge clock);
    start = 1'b0;
    scramble();
    wait_done("held_b");

    // Clear in the middle of an operation drops it and forces the reset outputs at once.
    issue(3'd0, 32'hDEAD_BEEF, 32'd20, 0, 0);
    if (!FAST) repeat (15) @(negedge clock);
    clear = 1'b1;
    #1;
    chk("clr_busy", busy, 1'b0);
    chk("clr_done", done, 1'b0);
    chk("clr_result", result, 32'd0);
    chk("clr_zero", zero, 1'b1);
    chk("clr_illegal", illegal, 1'b0);
    exp_q.delete();
    @(negedge clock);
    clear = 1'b0;
    issue(3'd4, 32'h1234_5678, 32'd8, 0, 1);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      rd = (i % 7 == 0) ? 32'd0 : $urandom;
      ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      issue(ro, rd, ra, (i % 5 == 0), 1);
    end

    repeat (5) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_busy", busy, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
